uart_rx_deserializer: RTL and testbench
=======================================

UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 8, meaning CLK cycles per UART bit; the only supported value is 8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-003 SHALL have port CLK  input  1  single clock for all logic, rising edge; frequency is OVERSAMPLE x bit rate.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high, already synchronized to CLK.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port P_DATA  output  DATA_WIDTH  last correctly received byte.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 SHALL have port par_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 SHALL have port stop_err  output  1  one-cycle pulse on stop bit sampled low.

Function
REQ-012 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL treat the first rising edge in IDLE at which RX_IN==0 as edge 0 of the frame.
- Frame bit k occupies edges 8k..8k+7.
- An internal edge counter runs 0..7 per bit and wraps.
- A bit counter counts data bits 0..DATA_WIDTH-1.
REQ-014 SHALL latch PAR_EN and PAR_TYP at edge 0 and use the latched values for the whole frame.
REQ-015 SHALL sample RX_IN at edge counts 3, 4 and 5 of each bit and take the bit value as the 2-of-3 majority.
REQ-016 SHALL evaluate each bit at edge count 7 and make state transitions at that edge.
REQ-017 SHALL handle START as follows:
- Majority 0 -> DATA.
- Majority 1 (glitch) -> IDLE, with no output pulse.
REQ-018 SHALL shift data bits in LSB first; after bit DATA_WIDTH-1 -> PARITY if latched PAR_EN, else -> STOP.
REQ-019 SHALL compute the expected parity bit as XOR of the received data bits for even parity and its inverse for odd parity; a mismatch flags a parity error.
REQ-020 SHALL end the frame at edge count 7 of STOP (frame edge 8N-1, where N = 10 without parity or 11 with), and at that edge register:
- data_valid=1 and P_DATA=received byte when there is no parity error and the stop majority is 1;
- otherwise par_err=1 and/or stop_err=1, data_valid=0, P_DATA unchanged.
Both errors may pulse together.
REQ-021 SHALL return to IDLE after the frame-end edge; the next edge may detect a new start bit, so back-to-back frames need no idle gap.
REQ-022 SHALL hold data_valid, par_err and stop_err high for exactly one CLK cycle per frame and low otherwise.
REQ-023 SHALL hold P_DATA stable between data_valid pulses.
REQ-024 SHALL ignore changes on PAR_EN/PAR_TYP mid-frame; they take effect from the next edge 0.

Reset
REQ-025 SHALL, on any rising edge with RST=1, set state=IDLE, all counters=0, shift register=0, P_DATA=0, data_valid=0, par_err=0, stop_err=0.
REQ-026 SHALL let reset take priority over all frame activity; a reset mid-frame aborts the frame with no output pulse.
REQ-027 SHALL not detect a start bit on the cycle RST is high; start detection resumes on the first edge with RST=0.

Verification
REQ-028 SHALL be verified with: PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity bit 0, stop 1 -> data_valid high exactly in the cycle after edge 87, P_DATA=0xA5, par_err=0, stop_err=0.
REQ-029 SHALL be verified with: PAR_EN=1, PAR_TYP=1, byte 0x3C sent with parity bit 0 -> par_err one-cycle pulse after edge 87, data_valid=0, P_DATA keeps its previous value.
REQ-030 SHALL be verified with: PAR_EN=0, byte 0x81, stop bit driven 0 -> stop_err pulse after edge 79, data_valid=0.
REQ-031 SHALL be verified with: RX_IN low for 2 cycles in IDLE, then high -> FSM back in IDLE after edge 7, no pulses, a following valid frame is received correctly.
REQ-032 SHALL be verified with: PAR_EN=0, frames 0x00 then 0xFF back-to-back with no idle gap -> two data_valid pulses 80 cycles apart, P_DATA=0x00 then 0xFF.
REQ-033 SHALL be verified with: RST=1 for one cycle at frame edge 40, then the line idles -> all outputs 0 and no pulse for the aborted frame.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8x oversampled, 2-of-3 majority per bit, optional even/odd parity.
// Emits one-cycle data_valid / par_err / stop_err pulses at the last edge of each frame.
module uart_rx_deserializer #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         edge_cnt_reg, edge_cnt_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
    logic                  par_en_reg, par_en_next;
    logic                  par_typ_reg, par_typ_next;
    logic                  par_bad_reg, par_bad_next;
    logic                  data_valid_reg, data_valid_next;
    logic                  par_err_reg, par_err_next;
    logic                  stop_err_reg, stop_err_next;
    logic [2:0]            sample_reg, sample_next;
    logic                  majority;
    logic                  last_edge;

    // Sample slot gi captures the line at edge count 3+gi of every bit.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sample
            assign sample_next[gi] = (state_reg != IDLE && edge_cnt_reg == CW'(3 + gi))
                                     ? RX_IN : sample_reg[gi];
        end
    endgenerate

    assign majority  = (sample_reg[0] & sample_reg[1]) | (sample_reg[0] & sample_reg[2])
                     | (sample_reg[1] & sample_reg[2]);
    assign last_edge = (edge_cnt_reg == CW'(OVERSAMPLE - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            edge_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            p_data_reg     <= '0;
            par_en_reg     <= 1'b0;
            par_typ_reg    <= 1'b0;
            par_bad_reg    <= 1'b0;
            data_valid_reg <= 1'b0;
            par_err_reg    <= 1'b0;
            stop_err_reg   <= 1'b0;
            sample_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            edge_cnt_reg   <= edge_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            p_data_reg     <= p_data_next;
            par_en_reg     <= par_en_next;
            par_typ_reg    <= par_typ_next;
            par_bad_reg    <= par_bad_next;
            data_valid_reg <= data_valid_next;
            par_err_reg    <= par_err_next;
            stop_err_reg   <= stop_err_next;
            sample_reg     <= sample_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        edge_cnt_next   = edge_cnt_reg + CW'(1);
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        p_data_next     = p_data_reg;
        par_en_next     = par_en_reg;
        par_typ_next    = par_typ_reg;
        par_bad_next    = par_bad_reg;
        data_valid_next = 1'b0;
        par_err_next    = 1'b0;
        stop_err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                edge_cnt_next = '0;
                // The detecting edge is frame edge 0, so counting resumes at 1.
                if (!RX_IN) begin
                    state_next    = START;
                    edge_cnt_next = CW'(1);
                    bit_cnt_next  = '0;
                    par_en_next   = PAR_EN;
                    par_typ_next  = PAR_TYP;
                    par_bad_next  = 1'b0;
                end
            end
            START: begin
                if (last_edge) begin
                    state_next = majority ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last_edge) begin
                    shift_next = {majority, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_cnt_reg == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = par_en_reg ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    par_bad_next = majority ^ (^shift_reg) ^ par_typ_reg;
                    state_next   = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    state_next = IDLE;
                    if (!par_bad_reg && majority) begin
                        data_valid_next = 1'b1;
                        p_data_next     = shift_reg;
                    end else begin
                        par_err_next  = par_bad_reg;
                        stop_err_next = !majority;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign P_DATA     = p_data_reg;
    assign data_valid = data_valid_reg;
    assign par_err    = par_err_reg;
    assign stop_err   = stop_err_reg;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are driven bit-by-bit and
// every output pulse is logged with the edge number at which it was registered.
module tb_uart_rx_deserializer;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;

    int vec_cnt;
    int miscompare_cnt;
    int edge_num;

    int         dv_edge_q[$];
    logic [7:0] dv_data_q[$];
    int         pe_edge_q[$];
    int         se_edge_q[$];

    uart_rx_deserializer #(.OVERSAMPLE(8), .DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial edge_num = 0;
    always @(posedge CLK) edge_num <= edge_num + 1;

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_edge_q.push_back(edge_num);
            dv_data_q.push_back(P_DATA);
        end
        if (par_err)  pe_edge_q.push_back(edge_num);
        if (stop_err) se_edge_q.push_back(edge_num);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        dv_edge_q.delete();
        dv_data_q.delete();
        pe_edge_q.delete();
        se_edge_q.delete();
    endtask

    // Drives one frame; flip_edge toggles PAR_EN/PAR_TYP mid-frame, abort_edge pulses RST.
    task automatic send_frame(input logic [7:0] d, input bit with_par, input bit par_bit,
                              input bit stop_bit, input int flip_edge, input int abort_edge,
                              output int start_edge);
        logic [10:0] frame;
        int          n;
        frame    = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[1 + i] = d[i];
        if (with_par) begin
            frame[9]  = par_bit;
            frame[10] = stop_bit;
            n = 11;
        end else begin
            frame[9] = stop_bit;
            n = 10;
        end
        start_edge = -1;
        for (int e = 0; e < n * 8; e++) begin
            RX_IN = frame[e / 8];
            RST   = (e == abort_edge);
            if (e == flip_edge) begin
                PAR_EN  = ~PAR_EN;
                PAR_TYP = ~PAR_TYP;
            end
            tick();
            if (e == 0) start_edge = edge_num;
            if (e == abort_edge) begin
                RST   = 1'b0;
                RX_IN = 1'b1;
                break;
            end
        end
    endtask

    int s0;
    int s1;

    initial begin
        vec_cnt        = 0;
        miscompare_cnt = 0;
        RST     = 1'b1;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        repeat (3) tick();
        check("rst_p_data",     32'(P_DATA),     32'h00);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_par_err",    32'(par_err),    32'h0);
        check("rst_stop_err",   32'(stop_err),   32'h0);
        RST = 1'b0;
        idle(3);

        // Even parity, 0xA5, parity bit 0; config toggled mid-frame must be ignored.
        clear_logs();
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 36, -1, s0);
        idle(4);
        check("a5_dv_count", 32'(dv_edge_q.size()), 32'd1);
        if (dv_edge_q.size() > 0) begin
            check("a5_dv_edge", 32'(dv_edge_q[0] - s0), 32'd87);
            check("a5_dv_data", 32'(dv_data_q[0]),      32'hA5);
        end
        check("a5_pe_count", 32'(pe_edge_q.size()), 32'd0);
        check("a5_se_count", 32'(se_edge_q.size()), 32'd0);
        check("a5_p_data",   32'(P_DATA),           32'hA5);

        // Odd parity, 0x3C (four ones) sent with parity 0 -> parity error.
        clear_logs();
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, -1, s0);
        idle(4);
        check("3c_pe_count", 32'(pe_edge_q.size()), 32'd1);
        if (pe_edge_q.size() > 0) check("3c_pe_edge", 32'(pe_edge_q[0] - s0), 32'd87);
        check("3c_dv_count", 32'(dv_edge_q.size()), 32'd0);
        check("3c_se_count", 32'(se_edge_q.size()), 32'd0);
        check("3c_p_data",   32'(P_DATA),           32'hA5);

        // No parity, 0x81 with stop bit 0 -> stop error.
        clear_logs();
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1, -1, s0);
        idle(4);
        check("81_se_count", 32'(se_edge_q.size()), 32'd1);
        if (se_edge_q.size() > 0) check("81_se_edge", 32'(se_edge_q[0] - s0), 32'd79);
        check("81_dv_count", 32'(dv_edge_q.size()), 32'd0);
        check("81_pe_count", 32'(pe_edge_q.size()), 32'd0);
        check("81_p_data",   32'(P_DATA),           32'hA5);

        // Two-cycle start glitch, then a real frame starting at edge 8.
        clear_logs();
        RX_IN = 1'b0;
        repeat (2) tick();
        RX_IN = 1'b1;
        repeat (6) tick();
        check("glitch_dv_count", 32'(dv_edge_q.size()), 32'd0);
        check("glitch_pe_count", 32'(pe_edge_q.size()), 32'd0);
        check("glitch_se_count", 32'(se_edge_q.size()), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, -1, s0);
        idle(4);
        check("after_glitch_dv_count", 32'(dv_edge_q.size()), 32'd1);
        if (dv_edge_q.size() > 0) begin
            check("after_glitch_dv_edge", 32'(dv_edge_q[0] - s0), 32'd79);
            check("after_glitch_dv_data", 32'(dv_data_q[0]),      32'h5A);
        end

        // Back-to-back 0x00 then 0xFF with no idle gap.
        clear_logs();
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, -1, -1, s0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, -1, s1);
        idle(4);
        check("b2b_start_gap", 32'(s1 - s0),          32'd80);
        check("b2b_dv_count",  32'(dv_edge_q.size()), 32'd2);
        if (dv_edge_q.size() > 1) begin
            check("b2b_dv0_edge", 32'(dv_edge_q[0] - s0),           32'd79);
            check("b2b_dv_gap",   32'(dv_edge_q[1] - dv_edge_q[0]), 32'd80);
            check("b2b_dv0_data", 32'(dv_data_q[0]),                32'h00);
            check("b2b_dv1_data", 32'(dv_data_q[1]),                32'hFF);
        end
        check("b2b_err_count", 32'(pe_edge_q.size() + se_edge_q.size()), 32'd0);

        // Reset at frame edge 40 aborts the frame silently.
        clear_logs();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1, 40, s0);
        idle(100);
        check("abort_dv_count", 32'(dv_edge_q.size()), 32'd0);
        check("abort_pe_count", 32'(pe_edge_q.size()), 32'd0);
        check("abort_se_count", 32'(se_edge_q.size()), 32'd0);
        check("abort_p_data",   32'(P_DATA),           32'h00);
        check("abort_dv_level", 32'(data_valid),       32'h0);

        // Receiver still works after the abort.
        clear_logs();
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1, -1, s0);
        idle(4);
        check("post_abort_dv_count", 32'(dv_edge_q.size()), 32'd1);
        check("post_abort_p_data",   32'(P_DATA),           32'h96);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
